debounce_toggle_bank: RTL

DEBOUNCE_TOGGLE_BANK -- requirements
Module: debounce_toggle_bank

---
 rtl/debounce_toggle_bank.sv | 119 +++++++++++
 1 files changed

// File: rtl/debounce_toggle_bank.sv
// Per-channel switch conditioning: 2-flop synchronizer, debounce, press/release/long-press
// pulses and an LED toggle register. Channels are fully independent.
module debounce_toggle_bank #(
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned DEBOUNCE_LIMIT   = 250000,
  parameter int unsigned LONG_PRESS_LIMIT = 25000000,
  parameter int unsigned TOGGLE_ON_PRESS  = 0
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic [NUM_CH-1:0] i_Toggle_Clr,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic [NUM_CH-1:0] o_Long_Press,
  output logic [NUM_CH-1:0] o_Toggle
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int unsigned HoldW = (LONG_PRESS_LIMIT > 0) ? $clog2(LONG_PRESS_LIMIT + 1) : 1;
  localparam logic [DbW-1:0]   DbLast  = DbW'(DEBOUNCE_LIMIT - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_PRESS_LIMIT);
  localparam bit LongEn   = (LONG_PRESS_LIMIT != 0);
  localparam bit OnPress  = (TOGGLE_ON_PRESS != 0);

  logic [NUM_CH-1:0] meta_q, sync_q;
  logic [NUM_CH-1:0] sw_q, sw_d;
  logic [NUM_CH-1:0] press_q, press_d;
  logic [NUM_CH-1:0] release_q, release_d;
  logic [NUM_CH-1:0] long_q, long_d;
  logic [NUM_CH-1:0] fired_q, fired_d;
  logic [NUM_CH-1:0] toggle_q, toggle_d;
  logic [DbW-1:0]    dcnt_q [NUM_CH];
  logic [DbW-1:0]    dcnt_d [NUM_CH];
  logic [HoldW-1:0]  hold_q [NUM_CH];
  logic [HoldW-1:0]  hold_d [NUM_CH];

  always_comb begin
    logic tog_ev;
    tog_ev    = 1'b0;
    sw_d      = sw_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    fired_d   = fired_q;
    toggle_d  = toggle_q;
    for (int c = 0; c < NUM_CH; c++) begin
      dcnt_d[c] = '0;
      hold_d[c] = '0;
    end

    for (int c = 0; c < NUM_CH; c++) begin
      // Any cycle of agreement wipes the count: no partial credit for glitches.
      if (sync_q[c] == sw_q[c]) begin
        dcnt_d[c] = '0;
      end else if (dcnt_q[c] == DbLast) begin
        dcnt_d[c] = '0;
        sw_d[c]   = sync_q[c];
      end else begin
        dcnt_d[c] = dcnt_q[c] + DbW'(1);
      end
      press_d[c]   = sw_d[c] & ~sw_q[c];
      release_d[c] = ~sw_d[c] & sw_q[c];

      if (sw_q[c]) begin
        hold_d[c] = (hold_q[c] == HoldMax) ? hold_q[c] : hold_q[c] + HoldW'(1);
      end
      long_d[c] = LongEn && sw_q[c] && (hold_q[c] != HoldMax) && (hold_d[c] == HoldMax);

      // Flag survives through the release pulse so that release can be suppressed.
      if (long_d[c]) begin
        fired_d[c] = 1'b1;
      end else if (release_q[c]) begin
        fired_d[c] = 1'b0;
      end

      tog_ev = OnPress ? press_q[c] : (release_q[c] & ~fired_q[c]);
      toggle_d[c] = i_Toggle_Clr[c] ? 1'b0 : (toggle_q[c] ^ tog_ev);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      meta_q    <= '0;
      sync_q    <= '0;
      sw_q      <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      fired_q   <= '0;
      toggle_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        dcnt_q[c] <= '0;
        hold_q[c] <= '0;
      end
    end else begin
      meta_q    <= i_Switch;
      sync_q    <= meta_q;
      sw_q      <= sw_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      fired_q   <= fired_d;
      toggle_q  <= toggle_d;
      for (int c = 0; c < NUM_CH; c++) begin
        dcnt_q[c] <= dcnt_d[c];
        hold_q[c] <= hold_d[c];
      end
    end
  end

  assign o_Switch     = sw_q;
  assign o_Press      = press_q;
  assign o_Release    = release_q;
  assign o_Long_Press = long_q;
  assign o_Toggle     = toggle_q;

endmodule
